// File: rtl/pool_window_seq.sv
// Sequences a row-major pixel stream into 2x2 stride-2 max-pool windows for POOL_PE:
// one SET plus three COMPAREs per window, then flags the PE's registered result.
module pool_window_seq #(
    parameter int   WORD_SIZE         = 16,
    parameter int   MAX_WIDTH         = 64,
    parameter int   W_BITS            = 7,
    parameter int   H_BITS            = 8,
    parameter logic POOL_CTRL_SET     = 1'b0,
    parameter logic POOL_CTRL_COMPARE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [W_BITS-1:0]    cfg_width,
    input  logic [H_BITS-1:0]    cfg_height,
    input  logic                 cfg_isize,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_data,
    output logic                 set_isize,
    output logic                 pool_ctrl,
    output logic [WORD_SIZE-1:0] pool_idata,
    input  logic [WORD_SIZE-1:0] pool_odata,
    output logic                 out_valid,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int LB_AW = $clog2(MAX_WIDTH);
    localparam logic [W_BITS:0] MAX_W = (W_BITS+1)'(MAX_WIDTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_EVEN = 3'd1;
    localparam logic [2:0] S_ODD0 = 3'd2;
    localparam logic [2:0] S_ODD1 = 3'd3;
    localparam logic [2:0] S_ODD2 = 3'd4;
    localparam logic [2:0] S_ODD3 = 3'd5;

    logic [2:0]           state;
    logic [W_BITS-1:0]    col;
    logic [H_BITS-1:0]    row;
    logic [W_BITS-1:0]    width_q;
    logic [H_BITS-1:0]    height_q;
    logic                 isize_q;
    logic [WORD_SIZE-1:0] p0;
    logic [WORD_SIZE-1:0] p1;
    logic                 out_valid_q;
    logic                 done_q;
    logic                 err_q;

    logic [WORD_SIZE-1:0] lb [MAX_WIDTH];
    logic [WORD_SIZE-1:0] lb_rd;
    logic [LB_AW-1:0]     lb_addr;

    logic accept;
    logic last_col;
    logic last_row;
    logic cfg_ok;

    assign lb_addr  = col[LB_AW-1:0];
    assign lb_rd    = lb[lb_addr];
    assign accept   = in_valid & in_ready;
    assign last_col = (col == width_q - W_BITS'(1));
    assign last_row = (row == height_q - H_BITS'(1));

    assign cfg_ok = !cfg_width[0] && (cfg_width >= W_BITS'(2)) && ({1'b0, cfg_width} <= MAX_W)
                    && !cfg_height[0] && (cfg_height >= H_BITS'(2));

    assign set_isize = isize_q;
    assign busy      = (state != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = pool_odata;
    assign done      = done_q;
    assign err       = err_q;

    // Idle feed (COMPARE with the PE's own value) keeps the PE result stable.
    always_comb begin
        in_ready   = 1'b0;
        pool_ctrl  = POOL_CTRL_COMPARE;
        pool_idata = pool_odata;
        if (!rst) begin
            case (state)
                S_EVEN: in_ready = 1'b1;
                S_ODD0: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        pool_ctrl  = POOL_CTRL_SET;
                        pool_idata = lb_rd;
                    end
                end
                S_ODD1: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        pool_idata = lb_rd;
                    end
                end
                S_ODD2: pool_idata = p0;
                S_ODD3: pool_idata = p1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_EVEN && accept) begin
            lb[lb_addr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            col         <= '0;
            row         <= '0;
            width_q     <= '0;
            height_q    <= '0;
            isize_q     <= 1'b0;
            p0          <= '0;
            p1          <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            width_q  <= cfg_width;
                            height_q <= cfg_height;
                            isize_q  <= cfg_isize;
                            col      <= '0;
                            row      <= '0;
                            state    <= S_EVEN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_EVEN: begin
                    if (accept) begin
                        if (last_col) begin
                            col   <= '0;
                            row   <= row + H_BITS'(1);
                            state <= S_ODD0;
                        end else begin
                            col <= col + W_BITS'(1);
                        end
                    end
                end
                S_ODD0: begin
                    if (accept) begin
                        p0    <= in_data;
                        col   <= col + W_BITS'(1);
                        state <= S_ODD1;
                    end
                end
                S_ODD1: begin
                    if (accept) begin
                        p1    <= in_data;
                        col   <= last_col ? '0 : col + W_BITS'(1);
                        state <= S_ODD2;
                    end
                end
                S_ODD2: state <= S_ODD3;
                S_ODD3: begin
                    out_valid_q <= 1'b1;
                    // col == 0 here means ODD1 just wrapped the row.
                    if (col == '0) begin
                        if (last_row) begin
                            done_q <= 1'b1;
                            state  <= S_IDLE;
                        end else begin
                            row   <= row + H_BITS'(1);
                            state <= S_EVEN;
                        end
                    end else begin
                        state <= S_ODD0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/pool_window_seq.md
# pool_window_seq

Sequencer that turns a row-major feature-map stream into 2x2, stride-2 max-pooling windows for the downstream `POOL_PE` stage. It buffers one even row in a line buffer. For each window it issues the four values to the PE as one SET and three COMPAREs, then flags the PE's registered result as a pooled output. It sits between the conv output stream and `POOL_PE`, and owns all `pool_ctrl`/`pool_idata` sequencing.

## Interface
- `WORD_SIZE`, 16, pixel word width; the PE treats it as one 16-bit lane or two 8-bit lanes.
- `MAX_WIDTH`, 64, line-buffer depth (max columns).
- `W_BITS`, 7, width of `cfg_width` and the column counter.
- `H_BITS`, 8, width of `cfg_height` and the row counter.
- `POOL_CTRL_SET`, 0 / `POOL_CTRL_COMPARE`, 1, encodings for `pool_ctrl`.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  one-cycle job start; sampled only in IDLE.
- `cfg_width`  in  W_BITS  columns; latched on start.
- `cfg_height`  in  H_BITS  rows; latched on start.
- `cfg_isize`  in  1  lane mode; 0 = 2x8-bit, 1 = 1x16-bit. Latched on start.
- `in_valid`  in  1  pixel valid.
- `in_ready`  out  1  pixel accepted when `in_valid & in_ready`.
- `in_data`  in  WORD_SIZE  pixel.
- `set_isize`  out  1  latched `cfg_isize`, routed to the PE.
- `pool_ctrl`  out  1  PE control.
- `pool_idata`  out  WORD_SIZE  PE operand.
- `pool_odata`  in  WORD_SIZE  PE registered result.
- `out_valid`  out  1  pooled result valid this cycle; no backpressure.
- `out_data`  out  WORD_SIZE  equals `pool_odata`; meaningful only when `out_valid` is high.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle pulse at the final output.
- `err`  out  1  one-cycle pulse on a rejected start.

## Operation
- **Start check.** On `start` in IDLE, the block requires `cfg_width` even, 2 ≤ `cfg_width` ≤ MAX_WIDTH, and `cfg_height` even, ≥ 2.
  - If the check fails: `err` pulses the next cycle and the block stays in IDLE.
  - If it passes: latch the configuration, clear `col`/`row`, go to EVEN.
- **States:** IDLE, EVEN, ODD0, ODD1, ODD2, ODD3.
- **EVEN.** `in_ready` = 1.
  - Each accepted pixel is written to `lb[col]` and `col` increments.
  - At `col` = W-1: `col` wraps to 0, `row` increments, go to ODD0.
- **ODD0.** `in_ready` = 1.
  - On accept: hold the pixel in `p0`, drive SET with `lb[col]`, `col` increments, go to ODD1.
- **ODD1.** `in_ready` = 1.
  - On accept: hold `p1`, drive COMPARE with `lb[col]`, `col` increments, go to ODD2.
- **ODD2.** `in_ready` = 0; drive COMPARE with `p0`; go to ODD3.
- **ODD3.** `in_ready` = 0; drive COMPARE with `p1`. Next state:
  - If `col` wrapped and `row` = H-1: IDLE.
  - Else if `col` wrapped: `row` increments, go to EVEN.
  - Else: ODD0.
- **Idle feed.** Any cycle without a feed above (IDLE, EVEN, ODD0/ODD1 without accept, reset) drives `pool_ctrl` = COMPARE and `pool_idata` = `pool_odata`. This leaves the PE value unchanged in both lane modes.
- **Output count.** A job produces (W/2)·(H/2) outputs.
  - `out_valid` is a register set by the ODD3 cycle.
  - `done` is asserted together with the last `out_valid`.
- **Busy.** `busy` = 1 in every state except IDLE. `start` while busy is ignored, with no `err`.
- **Line buffer.** Register array with asynchronous read. Contents are not reset.
- **No arithmetic on pixel data here.** Signed comparison and lane splitting happen in the PE. `set_isize` is held constant for the whole job.

## Timing
- **Reset values** (any cycle, including mid-job): state IDLE, `in_ready` 0, `out_valid` 0, `done` 0, `err` 0, `busy` 0, `set_isize` 0, counters 0, `pool_ctrl` = COMPARE, `pool_idata` = `pool_odata`.
  - A partial window is discarded.
  - Pixels already in flight are not re-requested.
- **Feed path.** `pool_ctrl`/`pool_idata` are combinational from state, `in_valid` and the holding registers. The PE samples them at the same edge as the accept.
- **Window latency.** Let T be the ODD3 cycle. `pool_odata` is final in cycle T+1; `out_valid` = 1 in T+1 only.
  - A SET fed in T+1 (back-to-back ODD0 accept) does not disturb `out_data` in T+1.
- **Throughput.** Even rows accept 1 pixel/cycle. Odd rows accept 2 pixels per 4 cycles, with minimum 2 bubble cycles per window.
- **Stalls.** A missing `in_valid` in ODD0/ODD1 stalls the state. The PE holds via idle feed.
- **Last window.** The ODD3 of the last window returns to IDLE. `busy` falls in T+1, with `out_valid` and `done` high in T+1.

## Test plan
- **16-bit basic.** Isize=1, W=4, H=2. Even row 1, 5, -3, 2; odd row 4, -7, 9, 0. Expect `out_data` 0x0005 then 0x0009; `done` with the second output; 2 outputs total.
- **Lane mode.** Isize=0, W=2, H=2. Window 0x7F80, 0x0101, 0x80FF, 0x0203. Expect 0x7F03 (per-lane signed max).
- **All-negative window.** Isize=1, 2x2 all 0x8000, then a second job with all 0xFFFF. Expect 0x8000 then 0xFFFF; the idle feed must not leak the earlier value.
- **Stalls.** Same stimulus as the 16-bit basic case, with `in_valid` toggling 1/0 every cycle. Expect identical outputs; `in_ready` low in ODD2/ODD3; no `out_valid` glitches.
- **Rejected starts.**
  - `start` with W=3 → `err` one cycle, `busy` stays 0.
  - `start` with W=MAX_WIDTH+2 → `err`.
  - `start` while busy → ignored; the running job completes unchanged.
- **Reset mid-job.** Reset during ODD1 of an 8x4 job → next cycle `in_ready`, `out_valid`, `busy` all 0. A fresh 4x2 job then produces the correct 2 outputs.
